// File: rtl/quad_encoder_decoder.sv
// quad_encoder_decoder: synchronizes and debounces raw quadrature contacts, then
// decodes full detent-to-detent rotations into single-cycle step pulses.
module quad_encoder_decoder #(
  parameter int CLOCK_FREQ_MHZ = 100,
  parameter int DELAY_IN_US    = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic a_i,
  input  logic b_i,
  output logic a_clean_o,
  output logic b_clean_o,
  output logic inc_o,
  output logic dec_o,
  output logic err_o
);
  localparam int N  = CLOCK_FREQ_MHZ * DELAY_IN_US;
  localparam int CW = $clog2(N);
  if (N < 2) begin : g_bad_n
    $error("debounce window N=%0d must be at least 2 cycles", N);
  end
  typedef enum logic [2:0] {IDLE, R1, R2, R3, L1, L2, L3, WAIT} state_t;
  logic [1:0] meta_q, sync_q, clean_q, clean_d, mis, hit;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  state_t state_q, state_d;
  logic inc_q, dec_q, err_q, inc_d, dec_d, err_d;
  logic [1:0] ab;
  assign mis = sync_q ^ clean_q;
  always_comb begin
    hit = '0;
    cnt_d[0] = '0;
    cnt_d[1] = '0;
    for (int c = 0; c < 2; c++) begin
      hit[c] = mis[c] && cnt_q[c] == CW'(N - 1);
      cnt_d[c] = (mis[c] && !hit[c]) ? cnt_q[c] + CW'(1) : '0;
    end
  end
  assign clean_d = (clean_q & ~hit) | (sync_q & hit);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q  <= 2'b11;
      sync_q  <= 2'b11;
      clean_q <= 2'b11;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      meta_q  <= {a_i, b_i};
      sync_q  <= meta_q;
      clean_q <= clean_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end
  assign ab = clean_q;
  // contact pair each non-WAIT state represents; flipping both bits from it is illegal
  function automatic logic [1:0] code(input state_t s);
    case (s)
      R1, L3:  code = 2'b01;
      R2, L2:  code = 2'b00;
      R3, L1:  code = 2'b10;
      default: code = 2'b11;
    endcase
  endfunction
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = ab == 2'b01 ? R1 : ab == 2'b10 ? L1 : ab == 2'b00 ? WAIT : IDLE;
      R1:   state_d = ab == 2'b00 ? R2 : ab == 2'b11 ? IDLE : ab == 2'b10 ? WAIT : R1;
      R2:   state_d = ab == 2'b10 ? R3 : ab == 2'b01 ? R1 : ab == 2'b11 ? WAIT : R2;
      R3:   state_d = ab == 2'b11 ? IDLE : ab == 2'b00 ? R2 : ab == 2'b01 ? WAIT : R3;
      L1:   state_d = ab == 2'b00 ? L2 : ab == 2'b11 ? IDLE : ab == 2'b01 ? WAIT : L1;
      L2:   state_d = ab == 2'b01 ? L3 : ab == 2'b10 ? L1 : ab == 2'b11 ? WAIT : L2;
      L3:   state_d = ab == 2'b11 ? IDLE : ab == 2'b00 ? L2 : ab == 2'b10 ? WAIT : L3;
      default: state_d = ab == 2'b11 ? IDLE : WAIT;
    endcase
  end
  always_comb begin
    inc_d = state_q == R3 && ab == 2'b11;
    dec_d = state_q == L3 && ab == 2'b11;
    err_d = state_q != WAIT && (ab ^ code(state_q)) == 2'b11;
    a_clean_o = clean_q[1];
    b_clean_o = clean_q[0];
    inc_o = inc_q;
    dec_o = dec_q;
    err_o = err_q;
  end
endmodule

// File: tb/tb_quad_encoder_decoder.sv
// tb_quad_encoder_decoder: directed bench for the encoder front end at N=100 cycles.
module tb_quad_encoder_decoder;
  logic clk = 1'b0, rst = 1'b1, a = 1'b1, b = 1'b1;
  logic a_clean, b_clean, inc, dec, err;
  int cyc = 0, errors = 0, checks = 0;
  int inc_cnt = 0, dec_cnt = 0, err_cnt = 0, inc_at = -1, dec_at = -1, err_at = -1;
  int a_fall_cnt = 0, a_rise_cnt = 0, a_fall_at = -1;
  logic prev_ac = 1'b1, p_inc = 1'b0, p_dec = 1'b0, p_err = 1'b0;
  bit overlap = 1'b0, wide = 1'b0;

  quad_encoder_decoder #(.CLOCK_FREQ_MHZ(100), .DELAY_IN_US(1)) dut (
    .clk_i(clk), .rst_i(rst), .a_i(a), .b_i(b),
    .a_clean_o(a_clean), .b_clean_o(b_clean),
    .inc_o(inc), .dec_o(dec), .err_o(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (inc === 1'b1) begin inc_cnt++; inc_at = cyc; end
    if (dec === 1'b1) begin dec_cnt++; dec_at = cyc; end
    if (err === 1'b1) begin err_cnt++; err_at = cyc; end
    if ($countones({inc === 1'b1, dec === 1'b1, err === 1'b1}) > 1) overlap = 1'b1;
    if ((inc === 1'b1 && p_inc) || (dec === 1'b1 && p_dec) || (err === 1'b1 && p_err)) wide = 1'b1;
    p_inc = inc === 1'b1;
    p_dec = dec === 1'b1;
    p_err = err === 1'b1;
    if (prev_ac === 1'b1 && a_clean === 1'b0) begin a_fall_cnt++; a_fall_at = cyc; end
    if (prev_ac === 1'b0 && a_clean === 1'b1) a_rise_cnt++;
    prev_ac = a_clean;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic wave(input int u);
    if (u < 0) return 1'b1;
    if (u < 100) return (u % 10) < 5;
    if (u < 600) return 1'b0;
    if (u < 700) return (u % 10) < 5;
    return 1'b1;
  endfunction

  // A leads for right, B leads for left; k = edge that samples the final rising contact
  task automatic rotate(input bit left, input int stop, output int k);
    logic wa, wb;
    k = 0;
    for (int t = 0; t < stop; t++) begin
      @(negedge clk);
      wa = wave(t);
      wb = wave(t - 300);
      a = left ? wb : wa;
      b = left ? wa : wb;
      if (t == 1000) k = cyc + 1;
    end
  endtask

  task automatic hold(input logic va, input logic vb, input int n, output int k);
    k = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) k = cyc + 1;
      a = va;
      b = vb;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int k, si, sd, se, sf, sr;
    idle(3);
    check("rst_a_clean", a_clean, 1);
    check("rst_b_clean", b_clean, 1);
    check("rst_inc", inc, 0);
    check("rst_dec", dec, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    idle(5);

    si = inc_cnt; sd = dec_cnt; se = err_cnt;
    rotate(1'b0, 1100, k);
    idle(100);
    check("right_inc", inc_cnt - si, 1);
    check("right_dec", dec_cnt - sd, 0);
    check("right_err", err_cnt - se, 0);
    check("right_latency", inc_at - k, 102);

    si = inc_cnt; sd = dec_cnt; se = err_cnt;
    rotate(1'b1, 1100, k);
    idle(100);
    check("left_dec", dec_cnt - sd, 1);
    check("left_inc", inc_cnt - si, 0);
    check("left_err", err_cnt - se, 0);
    check("left_latency", dec_at - k, 102);

    sf = a_fall_cnt;
    hold(1'b0, 1'b1, 99, k);
    hold(1'b1, 1'b1, 150, k);
    check("glitch99_no_fall", a_fall_cnt - sf, 0);
    check("glitch99_a_clean", a_clean, 1);
    si = inc_cnt; sd = dec_cnt; se = err_cnt;
    hold(1'b0, 1'b1, 100, k);
    hold(1'b1, 1'b1, 150, sr);
    check("low100_fall", a_fall_cnt - sf, 1);
    check("low100_fall_edge", a_fall_at - k, 101);
    check("low100_pulses", (inc_cnt - si) + (dec_cnt - sd) + (err_cnt - se), 0);

    sf = a_fall_cnt; sr = a_rise_cnt; si = inc_cnt; sd = dec_cnt; se = err_cnt;
    hold(1'b0, 1'b1, 300, k);
    hold(1'b1, 1'b1, 300, k);
    check("half_fall", a_fall_cnt - sf, 1);
    check("half_rise", a_rise_cnt - sr, 1);
    check("half_a_clean", a_clean, 1);
    check("half_pulses", (inc_cnt - si) + (dec_cnt - sd) + (err_cnt - se), 0);

    si = inc_cnt; sd = dec_cnt; se = err_cnt;
    hold(1'b0, 1'b0, 300, k);
    hold(1'b1, 1'b1, 300, sr);
    check("illegal_err", err_cnt - se, 1);
    check("illegal_err_edge", err_at - k, 102);
    check("illegal_inc_dec", (inc_cnt - si) + (dec_cnt - sd), 0);
    check("illegal_ab_back", {a_clean, b_clean}, 2'b11);
    si = inc_cnt;
    rotate(1'b0, 1100, k);
    idle(100);
    check("after_illegal_inc", inc_cnt - si, 1);

    rotate(1'b0, 550, k);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_a_clean", a_clean, 1);
    check("midrst_b_clean", b_clean, 1);
    check("midrst_inc", inc, 0);
    check("midrst_dec", dec, 0);
    check("midrst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    si = inc_cnt; sd = dec_cnt; se = err_cnt;
    hold(1'b0, 1'b0, 300, k);
    hold(1'b1, 1'b0, 300, k);
    hold(1'b1, 1'b1, 300, k);
    check("midrst_no_inc", inc_cnt - si, 0);
    check("midrst_no_dec", dec_cnt - sd, 0);
    check("midrst_err_00", err_cnt - se, 1);
    si = inc_cnt;
    rotate(1'b0, 1100, k);
    idle(100);
    check("after_rst_inc", inc_cnt - si, 1);
    check("after_rst_latency", inc_at - k, 102);

    check("pulses_exclusive", overlap, 0);
    check("pulses_one_cycle", wide, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
